mem_access_stage: RTL and testbench

- Pipeline memory stage between execute and write-back.
- Registers the execute result and control word, and performs the LW/SW data-memory transaction over a req/ack handshake.
- Presents lData, result_fromALU, wb_iCont and done_out to write-back.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 38 +++
 rtl/mem_access_stage_timeout_ctr.sv | 27 ++
 rtl/mem_access_stage.sv | 114 +++++++++++
 tb/tb_mem_access_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access pipeline stage: control word, memory op, FSM state.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE = 2'd0,
        MEM_OP_LW   = 2'd1,
        MEM_OP_SW   = 2'd2
    } mem_op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        mem_op_t    mem_op;
        logic       reg_write;
        logic [4:0] rd;
    } f_dec_t;

    typedef struct packed {
        logic [31:0] pc;
        f_dec_t      f_dec;
    } instr_structure;

    function automatic logic is_mem_op(input mem_op_t op);
        return (op == MEM_OP_LW) || (op == MEM_OP_SW);
    endfunction

    // An aborted access is handed on as a store so write-back never writes rd.
    function automatic instr_structure suppress_wb(input instr_structure c);
        instr_structure r;
        r              = c;
        r.f_dec.mem_op = MEM_OP_SW;
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// Access watchdog: counts ACCESS cycles without ack and flags expiry (used with MEM_TIMEOUT_EN).
module mem_timeout_ctr #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick)
            count <= count + 1'b1;
    end

    // Fires during the LIMIT-th waiting cycle so the FSM leaves ACCESS on that edge.
    assign expired = tick && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage between execute and write-back; LW/SW over a req/ack data-memory handshake.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done_in,
    input  logic [31:0]         alu_result_in,
    input  logic [31:0]         store_data_in,
    input  instr_structure      mem_iCont,
    output logic                stall_out,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic [31:0]         lData,
    output logic [31:0]         result_fromALU,
    output instr_structure      wb_iCont,
    output logic                done_out,
    output logic                mem_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_t     state;
    logic [31:0]    alu_q;
    logic [31:0]    wdata_q;
    instr_structure cont_q;
    logic           accept_mem;
    logic           timeout_hit;

    assign accept_mem = (state == IDLE) && done_in && is_mem_op(mem_iCont.f_dec.mem_op);

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept_mem),
        .tick    ((state == ACCESS) && !dmem_ack),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Handshake outputs come straight from registered state, so reset drops dmem_req at once.
    assign stall_out  = (state == ACCESS);
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = (state == ACCESS) && (cont_q.f_dec.mem_op == MEM_OP_SW);
    assign dmem_addr  = {alu_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            alu_q          <= '0;
            wdata_q        <= '0;
            cont_q         <= '0;
            lData          <= '0;
            result_fromALU <= '0;
            wb_iCont       <= '0;
            done_out       <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each edge; non-blocking so every branch sees old state.
            done_out <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_in) begin
                        if (accept_mem) begin
                            alu_q   <= alu_result_in;
                            wdata_q <= store_data_in;
                            cont_q  <= mem_iCont;
                            state   <= ACCESS;
                        end else begin
                            result_fromALU <= alu_result_in;
                            wb_iCont       <= mem_iCont;
                            done_out       <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        if (cont_q.f_dec.mem_op == MEM_OP_LW)
                            lData <= dmem_rdata;
                        result_fromALU <= alu_q;
                        wb_iCont       <= cont_q;
                        done_out       <= 1'b1;
                        state          <= IDLE;
                    end else if (timeout_hit) begin
                        result_fromALU <= alu_q;
                        wb_iCont       <= suppress_wb(cont_q);
                        done_out       <= 1'b1;
                        mem_err        <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; inputs change and outputs are sampled on the falling edge.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           done_in;
    logic [31:0]    alu_result_in;
    logic [31:0]    store_data_in;
    instr_structure mem_iCont;
    logic           stall_out;
    logic           dmem_req;
    logic           dmem_we;
    logic [31:0]    dmem_addr;
    logic [31:0]    dmem_wdata;
    logic           dmem_ack;
    logic [31:0]    dmem_rdata;
    logic [31:0]    lData;
    logic [31:0]    result_fromALU;
    instr_structure wb_iCont;
    logic           done_out;
    logic           mem_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .done_in        (done_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .mem_iCont      (mem_iCont),
        .stall_out      (stall_out),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .lData          (lData),
        .result_fromALU (result_fromALU),
        .wb_iCont       (wb_iCont),
        .done_out       (done_out),
        .mem_err        (mem_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] sdata, input instr_structure c);
        done_in       = 1'b1;
        alu_result_in = alu;
        store_data_in = sdata;
        mem_iCont     = c;
    endtask

    instr_structure cont_alu, cont_alu2, cont_lw, cont_lw2, cont_sw;
    int             stall_cycles;

    initial begin
        cont_alu  = '{pc: 32'h0000_0100, f_dec: '{mem_op: MEM_OP_NONE, reg_write: 1'b1, rd: 5'd3}};
        cont_alu2 = '{pc: 32'h0000_0110, f_dec: '{mem_op: MEM_OP_NONE, reg_write: 1'b1, rd: 5'd9}};
        cont_lw   = '{pc: 32'h0000_0104, f_dec: '{mem_op: MEM_OP_LW,   reg_write: 1'b1, rd: 5'd4}};
        cont_lw2  = '{pc: 32'h0000_010C, f_dec: '{mem_op: MEM_OP_LW,   reg_write: 1'b1, rd: 5'd7}};
        cont_sw   = '{pc: 32'h0000_0108, f_dec: '{mem_op: MEM_OP_SW,   reg_write: 1'b0, rd: 5'd0}};

        rst = 1'b1; done_in = 1'b0; alu_result_in = '0; store_data_in = '0;
        mem_iCont = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_done",   done_out, 0);
        check("rst_req",    dmem_req, 0);
        check("rst_stall",  stall_out, 0);
        check("rst_result", result_fromALU, 0);
        check("rst_ldata",  lData, 0);
        check("rst_wb",     wb_iCont, 0);
        check("rst_err",    mem_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // ALU op: one-cycle latency, no memory request
        issue(32'h0000_1234, 32'h0, cont_alu);
        check("alu_req_pre", dmem_req, 0);
        @(negedge clk);
        done_in = 1'b0;
        check("alu_done",   done_out, 1);
        check("alu_result", result_fromALU, 32'h0000_1234);
        check("alu_wb",     wb_iCont, cont_alu);
        check("alu_req",    dmem_req, 0);
        @(negedge clk);
        check("alu_done_off", done_out, 0);
        check("alu_hold",   result_fromALU, 32'h0000_1234);

        // LW misaligned, ack on the third ACCESS cycle
        issue(32'h0000_0103, 32'h0, cont_lw);
        @(negedge clk);
        done_in = 1'b0;
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            check("lw_req",   dmem_req, 1);
            check("lw_we",    dmem_we, 0);
            check("lw_addr",  dmem_addr, 32'h0000_0100);
            check("lw_nodone", done_out, 0);
            if (stall_out) stall_cycles++;
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        check("lw_stall_cycles", stall_cycles, 3);
        check("lw_done",   done_out, 1);
        check("lw_ldata",  lData, 32'hDEAD_BEEF);
        check("lw_result", result_fromALU, 32'h0000_0103);
        check("lw_wb",     wb_iCont, cont_lw);
        check("lw_stall_off", stall_out, 0);
        check("lw_req_off",   dmem_req, 0);
        @(negedge clk);
        check("lw_done_off", done_out, 0);

        // SW, ack on first ACCESS cycle
        issue(32'h0000_0040, 32'h5A5A_5A5A, cont_sw);
        @(negedge clk);
        done_in = 1'b0;
        check("sw_req",   dmem_req, 1);
        check("sw_we",    dmem_we, 1);
        check("sw_wdata", dmem_wdata, 32'h5A5A_5A5A);
        check("sw_addr",  dmem_addr, 32'h0000_0040);
        check("sw_nodone", done_out, 0);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("sw_done",  done_out, 1);
        check("sw_ldata", lData, 32'hDEAD_BEEF);
        check("sw_wb",    wb_iCont, cont_sw);
        @(negedge clk);
        check("sw_done_off", done_out, 0);

        // Stray ack in IDLE is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("stray_done",  done_out, 0);
        check("stray_ldata", lData, 32'hDEAD_BEEF);
        check("stray_stall", stall_out, 0);

        // Back-to-back: LW then an ALU op held during the stall
        issue(32'h0000_0200, 32'h0, cont_lw2);
        @(negedge clk);
        issue(32'h0000_0077, 32'h0, cont_alu2);
        check("b2b_stall", stall_out, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("b2b_lw_done",   done_out, 1);
        check("b2b_lw_ldata",  lData, 32'hCAFE_F00D);
        check("b2b_lw_result", result_fromALU, 32'h0000_0200);
        check("b2b_lw_wb",     wb_iCont, cont_lw2);
        check("b2b_stall_off", stall_out, 0);
        @(negedge clk);
        done_in = 1'b0;
        check("b2b_alu_done",   done_out, 1);
        check("b2b_alu_result", result_fromALU, 32'h0000_0077);
        check("b2b_alu_wb",     wb_iCont, cont_alu2);
        check("b2b_alu_ldata",  lData, 32'hCAFE_F00D);
        @(negedge clk);
        check("b2b_done_off", done_out, 0);

        // Reset in the middle of an access
        issue(32'h0000_0300, 32'h0, cont_lw);
        @(negedge clk);
        done_in = 1'b0;
        check("rma_req_before", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rma_req",   dmem_req, 0);
        check("rma_done",  done_out, 0);
        check("rma_stall", stall_out, 0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rma_no_pulse", done_out, 0);
        check("rma_idle",     stall_out, 0);
        check("rma_err",      mem_err, 0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after four ACCESS cycles
        issue(32'h0000_0400, 32'h0, cont_lw);
        @(negedge clk);
        done_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_stall", stall_out, 1);
            check("tmo_err_low", mem_err, 0);
            @(negedge clk);
        end
        check("tmo_done",   done_out, 1);
        check("tmo_err",    mem_err, 1);
        check("tmo_mem_op", wb_iCont.f_dec.mem_op, MEM_OP_SW);
        check("tmo_result", result_fromALU, 32'h0000_0400);
        check("tmo_stall_off", stall_out, 0);
        @(negedge clk);
        check("tmo_err_off", mem_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
